axi_slave128_arb: RTL and testbench
===================================

// Module: axi_slave128_arb
// PURPOSE
//  Two-master round-robin arbiter in front of the single-outstanding 128-bit AXI
//  memory slave (port suffix _s0). Grants one master for one complete
//  transaction (AR..RLAST or AW..WLAST..B), routes all five channels, and holds
//  every other master's valid/ready at 0. No buffering: the data path is
//  combinational; only address issue adds one arbitration cycle.
// PARAMETERS
//  ADDR_W  40   address width, all AR/AW ports
//  ID_W    8    AXI ID width
//  DATA_W  128  data width; strobe width is DATA_W/8
// PORTS (m=0,1; payload widths in field order)
//  pll_core_cpuclk   in   1   single clock, rising edge
//  pad_cpu_rst       in   1   asynchronous reset, active-high
//  ar{addr,burst,cache,id,len,prot,size}_m{m}  in  ADDR_W/2/4/ID_W/8/3/3  AR payload, master m
//  arvalid_m{m} in 1 / arready_m{m} out 1     AR handshake, master m
//  aw{addr,burst,cache,id,len,prot,size}_m{m}  in  ADDR_W/2/4/ID_W/8/3/3  AW payload, master m
//  awvalid_m{m} in 1 / awready_m{m} out 1     AW handshake, master m
//  w{data,id,strb,last}_m{m}  in  DATA_W/ID_W/DATA_W/8/1  W payload; wvalid_m{m} in 1, wready_m{m} out 1
//  r{data,id,resp,last}_m{m}  out DATA_W/ID_W/2/1  R payload; rvalid_m{m} out 1, rready_m{m} in 1
//  b{id,resp}_m{m}  out ID_W/2  B payload; bvalid_m{m} out 1, bready_m{m} in 1
//  ar*/aw*/w*_s0 out, r*/b*_s0 in  same fields and widths  slave side, plus the opposing valid/ready
//  arb_gnt       out  1   granted master index; valid when arb_busy=1
//  arb_busy      out  1   1 in any state other than IDLE
//  arb_wlast_err out  1   sticky: WLAST seen at a beat other than awlen, or missing at beat awlen
// BEHAVIOUR
//  - FSM (3b): IDLE, ADDR_RD, ADDR_WR, DATA_RD, DATA_WR, RESP_WR.
//  - IDLE: req_m = arvalid_m|awvalid_m. One requester -> grant it. Both -> grant
//    the master != last_gnt. Grant, last_gnt and kind are registered. AR wins
//    over AW within the granted master. Next state is ADDR_RD or ADDR_WR.
//    Nothing is forwarded to _s0 while in IDLE.
//  - ADDR_RD: arvalid_s0=arvalid_mg, ar*_s0=ar*_mg, arready_mg=arready_s0.
//    On handshake -> DATA_RD; latch arlen.
//  - DATA_RD: rvalid_mg=rvalid_s0, rready_s0=rready_mg. On rvalid&rready&rlast -> IDLE.
//  - ADDR_WR: same routing as ADDR_RD on AW; latch awlen; on handshake -> DATA_WR.
//  - DATA_WR: wvalid_s0=wvalid_mg, wready_mg=wready_s0, w*_s0=w*_mg.
//    An 8b beat counter increments on each W handshake and clears on entry.
//    Exit -> RESP_WR on the handshake where wlast_mg=1 OR count==awlen;
//    arb_wlast_err is set if those two conditions differ.
//  - RESP_WR: bvalid_mg=bvalid_s0, bready_s0=bready_mg. On handshake -> IDLE.
//  - R/B payload is broadcast to both masters; only the granted master's valid
//    is asserted. Non-granted master: all readys/valids 0.
//  - _s0 valids are 0 outside their own phase; _s0 payload is 0 when not routed.
//  - Latency: grant takes 1 cycle from IDLE; back-to-back transactions spend
//    >=1 IDLE cycle between them. Data/response paths add 0 cycles.
//  - Fairness: with both masters always requesting, grants alternate 0,1,0,1.
//  - Reset (async, any state): state=IDLE, last_gnt=1 (m0 wins the first tie),
//    beat count=0, arb_wlast_err=0, all valid/ready outputs=0, arb_busy=0, arb_gnt=0.
//    An in-flight transaction is dropped; the slave shares the reset.
//  - Valid drop before handshake is an AXI violation; the FSM simply waits.
// TESTING
//  1 m0 AR len=3 @0x100 alone -> arb_gnt=0; 4 R beats to m0; rlast on beat 4;
//    IDLE 1 cycle later; m1 never sees rvalid.
//  2 m0,m1 AR same cycle from reset -> m0 served first, then m1;
//    repeated for 4 rounds -> order 0,1,0,1,...
//  3 m1 AW len=1 + 2 W beats, strb 16'hffff -> 2 beats reach _s0; bvalid_m1
//    with bid=awid_m1; arb_wlast_err=0.
//  4 m0 with AR and AW both valid -> AR served first, AW next; the m1
//    request pending meanwhile is granted between them per round robin.
//  5 AW len=3 with wlast on beat 2 -> RESP_WR after beat 2; arb_wlast_err=1
//    and stays 1 until reset.
//  6 pad_cpu_rst pulsed in DATA_RD beat 2 -> outputs 0 the same cycle;
//    a fresh read afterwards completes normally.

Source files
------------

// File: rtl/axi_slave128_arb_if.sv
// One AXI port (AR/AW/W/R/B channels) between a master and a slave.
// Used for both the arbiter's upstream master ports and its single downstream slave port.
interface axi_slave128_arb_if #(
   parameter int ADDR_W = 40,
   parameter int ID_W   = 8,
   parameter int DATA_W = 128
);
   logic [ADDR_W-1:0]   araddr;
   logic [1:0]          arburst;
   logic [3:0]          arcache;
   logic [ID_W-1:0]     arid;
   logic [7:0]          arlen;
   logic [2:0]          arprot;
   logic [2:0]          arsize;
   logic                arvalid;
   logic                arready;

   logic [ADDR_W-1:0]   awaddr;
   logic [1:0]          awburst;
   logic [3:0]          awcache;
   logic [ID_W-1:0]     awid;
   logic [7:0]          awlen;
   logic [2:0]          awprot;
   logic [2:0]          awsize;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [ID_W-1:0]     wid;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [DATA_W-1:0]   rdata;
   logic [ID_W-1:0]     rid;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arburst, arcache, arid, arlen, arprot, arsize, arvalid,
      input  arready,
      output awaddr, awburst, awcache, awid, awlen, awprot, awsize, awvalid,
      input  awready,
      output wdata, wid, wstrb, wlast, wvalid,
      input  wready,
      input  rdata, rid, rresp, rlast, rvalid,
      output rready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  araddr, arburst, arcache, arid, arlen, arprot, arsize, arvalid,
      output arready,
      input  awaddr, awburst, awcache, awid, awlen, awprot, awsize, awvalid,
      output awready,
      input  wdata, wid, wstrb, wlast, wvalid,
      output wready,
      output rdata, rid, rresp, rlast, rvalid,
      input  rready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_slave128_arb.sv
// Two-master round-robin arbiter in front of a single-outstanding 128-bit AXI slave.
// One master owns the slave for a whole transaction; data paths are purely combinational.
module axi_slave128_arb #(
   parameter int ADDR_W = 40,
   parameter int ID_W   = 8,
   parameter int DATA_W = 128
) (
   input  logic                 pll_core_cpuclk,
   input  logic                 pad_cpu_rst,
   axi_slave128_arb_if.slave    m0,
   axi_slave128_arb_if.slave    m1,
   axi_slave128_arb_if.master   s0,
   output logic                 arb_gnt,
   output logic                 arb_busy,
   output logic                 arb_wlast_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_RD = 3'd1,
      ADDR_WR = 3'd2,
      DATA_RD = 3'd3,
      DATA_WR = 3'd4,
      RESP_WR = 3'd5
   } state_t;

   state_t     state, nxt_state;
   logic       gnt, last_gnt, pick;
   logic [7:0] len_q, beat_cnt;
   logic       wlast_err;

   logic                req0, req1;
   logic                g_arvalid, g_awvalid, g_wvalid, g_wlast, g_rready, g_bready;
   logic [ADDR_W-1:0]   g_araddr, g_awaddr;
   logic [ID_W-1:0]     g_arid, g_awid, g_wid;
   logic [7:0]          g_arlen, g_awlen;
   logic [DATA_W-1:0]   g_wdata;
   logic [DATA_W/8-1:0] g_wstrb;
   logic                ar_hs, aw_hs, w_hs, r_end, b_hs, beat_at_len;

   assign req0 = m0.arvalid | m0.awvalid;
   assign req1 = m1.arvalid | m1.awvalid;

   assign g_arvalid = gnt ? m1.arvalid : m0.arvalid;
   assign g_awvalid = gnt ? m1.awvalid : m0.awvalid;
   assign g_wvalid  = gnt ? m1.wvalid  : m0.wvalid;
   assign g_wlast   = gnt ? m1.wlast   : m0.wlast;
   assign g_rready  = gnt ? m1.rready  : m0.rready;
   assign g_bready  = gnt ? m1.bready  : m0.bready;
   assign g_araddr  = gnt ? m1.araddr  : m0.araddr;
   assign g_awaddr  = gnt ? m1.awaddr  : m0.awaddr;
   assign g_arid    = gnt ? m1.arid    : m0.arid;
   assign g_awid    = gnt ? m1.awid    : m0.awid;
   assign g_wid     = gnt ? m1.wid     : m0.wid;
   assign g_arlen   = gnt ? m1.arlen   : m0.arlen;
   assign g_awlen   = gnt ? m1.awlen   : m0.awlen;
   assign g_wdata   = gnt ? m1.wdata   : m0.wdata;
   assign g_wstrb   = gnt ? m1.wstrb   : m0.wstrb;

   assign ar_hs       = (state == ADDR_RD) && g_arvalid && s0.arready;
   assign aw_hs       = (state == ADDR_WR) && g_awvalid && s0.awready;
   assign w_hs        = (state == DATA_WR) && g_wvalid && s0.wready;
   assign r_end       = (state == DATA_RD) && s0.rvalid && g_rready && s0.rlast;
   assign b_hs        = (state == RESP_WR) && s0.bvalid && g_bready;
   assign beat_at_len = (beat_cnt == len_q);

   assign arb_gnt       = gnt;
   assign arb_busy      = (state != IDLE);
   assign arb_wlast_err = wlast_err;

   always_comb begin
      nxt_state = state;
      pick      = (req0 && req1) ? ~last_gnt : req1;
      case (state)
         IDLE: begin
            if (req0 || req1)
               nxt_state = (pick ? m1.arvalid : m0.arvalid) ? ADDR_RD : ADDR_WR;
         end
         ADDR_RD: if (ar_hs) nxt_state = DATA_RD;
         DATA_RD: if (r_end) nxt_state = IDLE;
         ADDR_WR: if (aw_hs) nxt_state = DATA_WR;
         DATA_WR: if (w_hs && (g_wlast || beat_at_len)) nxt_state = RESP_WR;
         RESP_WR: if (b_hs) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
      if (pad_cpu_rst) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last_gnt  <= 1'b1;
         len_q     <= '0;
         beat_cnt  <= '0;
         wlast_err <= 1'b0;
      end else begin
         state <= nxt_state;
         if (state == IDLE && nxt_state != IDLE) begin
            gnt      <= pick;
            last_gnt <= pick;
         end
         if (ar_hs) len_q <= g_arlen;
         if (aw_hs) len_q <= g_awlen;
         // Held at zero outside DATA_WR, so every write burst starts counting from beat 0.
         if (state != DATA_WR)
            beat_cnt <= '0;
         else if (w_hs)
            beat_cnt <= beat_cnt + 8'd1;
         if (w_hs && (g_wlast != beat_at_len))
            wlast_err <= 1'b1;
      end
   end

   always_comb begin
      s0.araddr  = '0;  s0.arburst = '0;  s0.arcache = '0;  s0.arid    = '0;
      s0.arlen   = '0;  s0.arprot  = '0;  s0.arsize  = '0;  s0.arvalid = 1'b0;
      s0.awaddr  = '0;  s0.awburst = '0;  s0.awcache = '0;  s0.awid    = '0;
      s0.awlen   = '0;  s0.awprot  = '0;  s0.awsize  = '0;  s0.awvalid = 1'b0;
      s0.wdata   = '0;  s0.wid     = '0;  s0.wstrb   = '0;  s0.wlast   = 1'b0;
      s0.wvalid  = 1'b0;
      s0.rready  = 1'b0;
      s0.bready  = 1'b0;

      m0.arready = 1'b0;  m0.awready = 1'b0;  m0.wready = 1'b0;
      m0.rvalid  = 1'b0;  m0.bvalid  = 1'b0;
      m1.arready = 1'b0;  m1.awready = 1'b0;  m1.wready = 1'b0;
      m1.rvalid  = 1'b0;  m1.bvalid  = 1'b0;

      // Response payload goes to both masters; only the granted one sees valid.
      m0.rdata = s0.rdata;  m0.rid = s0.rid;  m0.rresp = s0.rresp;  m0.rlast = s0.rlast;
      m1.rdata = s0.rdata;  m1.rid = s0.rid;  m1.rresp = s0.rresp;  m1.rlast = s0.rlast;
      m0.bid   = s0.bid;    m0.bresp = s0.bresp;
      m1.bid   = s0.bid;    m1.bresp = s0.bresp;

      case (state)
         ADDR_RD: begin
            s0.araddr  = g_araddr;
            s0.arburst = gnt ? m1.arburst : m0.arburst;
            s0.arcache = gnt ? m1.arcache : m0.arcache;
            s0.arid    = g_arid;
            s0.arlen   = g_arlen;
            s0.arprot  = gnt ? m1.arprot : m0.arprot;
            s0.arsize  = gnt ? m1.arsize : m0.arsize;
            s0.arvalid = g_arvalid;
            if (gnt) m1.arready = s0.arready;
            else     m0.arready = s0.arready;
         end
         DATA_RD: begin
            s0.rready = g_rready;
            if (gnt) m1.rvalid = s0.rvalid;
            else     m0.rvalid = s0.rvalid;
         end
         ADDR_WR: begin
            s0.awaddr  = g_awaddr;
            s0.awburst = gnt ? m1.awburst : m0.awburst;
            s0.awcache = gnt ? m1.awcache : m0.awcache;
            s0.awid    = g_awid;
            s0.awlen   = g_awlen;
            s0.awprot  = gnt ? m1.awprot : m0.awprot;
            s0.awsize  = gnt ? m1.awsize : m0.awsize;
            s0.awvalid = g_awvalid;
            if (gnt) m1.awready = s0.awready;
            else     m0.awready = s0.awready;
         end
         DATA_WR: begin
            s0.wdata  = g_wdata;
            s0.wid    = g_wid;
            s0.wstrb  = g_wstrb;
            s0.wlast  = g_wlast;
            s0.wvalid = g_wvalid;
            if (gnt) m1.wready = s0.wready;
            else     m0.wready = s0.wready;
         end
         RESP_WR: begin
            s0.bready = g_bready;
            if (gnt) m1.bvalid = s0.bvalid;
            else     m0.bvalid = s0.bvalid;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_slave128_arb.sv
// Directed bench for axi_slave128_arb: bench acts as both masters and as the slave,
// stepping each transaction cycle by cycle against hand-derived expectations.
module tb_axi_slave128_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   axi_slave128_arb_if #(.ADDR_W(40), .ID_W(8), .DATA_W(128)) m0_if ();
   axi_slave128_arb_if #(.ADDR_W(40), .ID_W(8), .DATA_W(128)) m1_if ();
   axi_slave128_arb_if #(.ADDR_W(40), .ID_W(8), .DATA_W(128)) s0_if ();

   logic arb_gnt, arb_busy, arb_wlast_err;

   axi_slave128_arb #(.ADDR_W(40), .ID_W(8), .DATA_W(128)) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst     (rst),
      .m0              (m0_if),
      .m1              (m1_if),
      .s0              (s0_if),
      .arb_gnt         (arb_gnt),
      .arb_busy        (arb_busy),
      .arb_wlast_err   (arb_wlast_err)
   );

   logic         arvalid[2], awvalid[2], wvalid[2], wlast[2], rready[2], bready[2];
   logic [39:0]  addr[2];
   logic [7:0]   len[2], id[2];
   logic [127:0] wdata[2];

   assign m0_if.araddr = addr[0];  assign m0_if.arburst = 2'b01;  assign m0_if.arcache = 4'h3;
   assign m0_if.arid   = id[0];    assign m0_if.arlen   = len[0]; assign m0_if.arprot  = 3'd0;
   assign m0_if.arsize = 3'd4;     assign m0_if.arvalid = arvalid[0];
   assign m0_if.awaddr = addr[0];  assign m0_if.awburst = 2'b01;  assign m0_if.awcache = 4'h3;
   assign m0_if.awid   = id[0];    assign m0_if.awlen   = len[0]; assign m0_if.awprot  = 3'd0;
   assign m0_if.awsize = 3'd4;     assign m0_if.awvalid = awvalid[0];
   assign m0_if.wdata  = wdata[0]; assign m0_if.wid     = id[0];  assign m0_if.wstrb   = 16'hffff;
   assign m0_if.wlast  = wlast[0]; assign m0_if.wvalid  = wvalid[0];
   assign m0_if.rready = rready[0]; assign m0_if.bready = bready[0];

   assign m1_if.araddr = addr[1];  assign m1_if.arburst = 2'b01;  assign m1_if.arcache = 4'h3;
   assign m1_if.arid   = id[1];    assign m1_if.arlen   = len[1]; assign m1_if.arprot  = 3'd0;
   assign m1_if.arsize = 3'd4;     assign m1_if.arvalid = arvalid[1];
   assign m1_if.awaddr = addr[1];  assign m1_if.awburst = 2'b01;  assign m1_if.awcache = 4'h3;
   assign m1_if.awid   = id[1];    assign m1_if.awlen   = len[1]; assign m1_if.awprot  = 3'd0;
   assign m1_if.awsize = 3'd4;     assign m1_if.awvalid = awvalid[1];
   assign m1_if.wdata  = wdata[1]; assign m1_if.wid     = id[1];  assign m1_if.wstrb   = 16'hffff;
   assign m1_if.wlast  = wlast[1]; assign m1_if.wvalid  = wvalid[1];
   assign m1_if.rready = rready[1]; assign m1_if.bready = bready[1];

   logic arready_o[2], awready_o[2], wready_o[2], rvalid_o[2], bvalid_o[2];
   logic [7:0] bid_o[2];
   assign arready_o[0] = m0_if.arready;  assign arready_o[1] = m1_if.arready;
   assign awready_o[0] = m0_if.awready;  assign awready_o[1] = m1_if.awready;
   assign wready_o[0]  = m0_if.wready;   assign wready_o[1]  = m1_if.wready;
   assign rvalid_o[0]  = m0_if.rvalid;   assign rvalid_o[1]  = m1_if.rvalid;
   assign bvalid_o[0]  = m0_if.bvalid;   assign bvalid_o[1]  = m1_if.bvalid;
   assign bid_o[0]     = m0_if.bid;      assign bid_o[1]     = m1_if.bid;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entry: FSM in IDLE with master m's arvalid already raised. Exit: FSM back in IDLE.
   task automatic serve_read(input int m, input logic [7:0] n);
      int o;
      logic [127:0] d;
      o = 1 - m;
      #1;
      chk("idle_no_fwd", {s0_if.arvalid, s0_if.awvalid}, 0);
      tick();
      chk("rd_busy", arb_busy, 1);
      chk("rd_gnt", arb_gnt, m[0]);
      chk("s0_arvalid", s0_if.arvalid, 1);
      chk("s0_araddr", s0_if.araddr, addr[m]);
      chk("s0_arlen", s0_if.arlen, n);
      chk("s0_arid", s0_if.arid, id[m]);
      chk("s0_awvalid_in_rd", s0_if.awvalid, 0);
      s0_if.arready = 1'b1;
      #1;
      chk("arready_gnt", arready_o[m], 1);
      chk("arready_other", arready_o[o], 0);
      tick();
      s0_if.arready = 1'b0;
      arvalid[m]    = 1'b0;
      for (int b = 0; b <= int'(n); b++) begin
         d = {addr[m], 80'h0, 8'(b)};
         s0_if.rvalid = 1'b1;
         s0_if.rdata  = d;
         s0_if.rid    = id[m];
         s0_if.rlast  = (b == int'(n));
         rready[m]    = 1'b1;
         #1;
         chk("rvalid_gnt", rvalid_o[m], 1);
         chk("rvalid_other", rvalid_o[o], 0);
         chk("rdata_m0", m0_if.rdata, d);
         chk("rdata_m1", m1_if.rdata, d);
         chk("rlast", (m == 0) ? m0_if.rlast : m1_if.rlast, (b == int'(n)));
         chk("s0_rready", s0_if.rready, 1);
         tick();
      end
      s0_if.rvalid = 1'b0;
      s0_if.rlast  = 1'b0;
      rready[m]    = 1'b0;
      #1;
      chk("rd_back_idle", arb_busy, 0);
      chk("rvalid_after", rvalid_o[m], 0);
   endtask

   // Entry: FSM in IDLE with master m's awvalid raised. wl = beat index carrying wlast.
   task automatic serve_write(input int m, input logic [7:0] n, input int wl, input logic exp_err);
      int o, e;
      logic [127:0] d;
      o = 1 - m;
      e = (wl < int'(n)) ? wl : int'(n);
      #1;
      chk("idle_no_fwd_w", {s0_if.arvalid, s0_if.awvalid}, 0);
      tick();
      chk("wr_busy", arb_busy, 1);
      chk("wr_gnt", arb_gnt, m[0]);
      chk("s0_awvalid", s0_if.awvalid, 1);
      chk("s0_awaddr", s0_if.awaddr, addr[m]);
      chk("s0_awlen", s0_if.awlen, n);
      chk("s0_awid", s0_if.awid, id[m]);
      chk("s0_arvalid_in_wr", s0_if.arvalid, 0);
      s0_if.awready = 1'b1;
      #1;
      chk("awready_gnt", awready_o[m], 1);
      chk("awready_other", awready_o[o], 0);
      tick();
      s0_if.awready = 1'b0;
      awvalid[m]    = 1'b0;
      for (int b = 0; b <= e; b++) begin
         d = {8'(b), 80'h0, addr[m]};
         wvalid[m]     = 1'b1;
         wdata[m]      = d;
         wlast[m]      = (b == wl);
         s0_if.wready  = 1'b1;
         #1;
         chk("s0_wvalid", s0_if.wvalid, 1);
         chk("s0_wdata", s0_if.wdata, d);
         chk("s0_wstrb", s0_if.wstrb, 16'hffff);
         chk("s0_wlast", s0_if.wlast, (b == wl));
         chk("s0_wid", s0_if.wid, id[m]);
         chk("wready_gnt", wready_o[m], 1);
         chk("wready_other", wready_o[o], 0);
         tick();
      end
      wvalid[m]    = 1'b0;
      wlast[m]     = 1'b0;
      s0_if.wready = 1'b0;
      #1;
      chk("resp_busy", arb_busy, 1);
      chk("s0_wvalid_off", s0_if.wvalid, 0);
      chk("bvalid_before", bvalid_o[m], 0);
      s0_if.bvalid = 1'b1;
      s0_if.bid    = id[m];
      s0_if.bresp  = 2'b00;
      bready[m]    = 1'b1;
      #1;
      chk("bvalid_gnt", bvalid_o[m], 1);
      chk("bvalid_other", bvalid_o[o], 0);
      chk("bid", bid_o[m], id[m]);
      chk("s0_bready", s0_if.bready, 1);
      tick();
      s0_if.bvalid = 1'b0;
      bready[m]    = 1'b0;
      #1;
      chk("wr_back_idle", arb_busy, 0);
      chk("wlast_err", arb_wlast_err, exp_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_busy", arb_busy, 0);
      chk("rst_gnt", arb_gnt, 0);
      chk("rst_err", arb_wlast_err, 0);
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         arvalid[i] = 1'b0; awvalid[i] = 1'b0; wvalid[i] = 1'b0; wlast[i] = 1'b0;
         rready[i]  = 1'b0; bready[i]  = 1'b0; wdata[i]  = '0;
         len[i]     = '0;
      end
      addr[0] = 40'h0000000100;  id[0] = 8'h11;
      addr[1] = 40'h0000002200;  id[1] = 8'h22;
      s0_if.arready = 1'b0; s0_if.awready = 1'b0; s0_if.wready = 1'b0;
      s0_if.rvalid  = 1'b0; s0_if.rdata   = '0;   s0_if.rid    = '0;
      s0_if.rresp   = '0;   s0_if.rlast   = 1'b0;
      s0_if.bvalid  = 1'b0; s0_if.bid     = '0;   s0_if.bresp  = '0;

      // reset state
      do_reset();
      chk("rst_s0_arvalid", s0_if.arvalid, 0);
      chk("rst_m0_arready", arready_o[0], 0);

      // 1: lone m0 read, len=3
      len[0] = 8'd3; arvalid[0] = 1'b1;
      serve_read(0, 8'd3);

      // 2: both read from reset, four alternating rounds
      do_reset();
      len[0] = 8'd1; len[1] = 8'd2;
      arvalid[0] = 1'b1; arvalid[1] = 1'b1;
      serve_read(0, 8'd1);
      arvalid[0] = 1'b1;
      serve_read(1, 8'd2);
      arvalid[1] = 1'b1;
      serve_read(0, 8'd1);
      serve_read(1, 8'd2);

      // 3: m1 write len=1, wlast on beat 1
      len[1] = 8'd1; awvalid[1] = 1'b1;
      serve_write(1, 8'd1, 1, 1'b0);

      // 4: m0 AR+AW together with m1 AR pending
      do_reset();
      len[0] = 8'd0; len[1] = 8'd1;
      arvalid[0] = 1'b1; awvalid[0] = 1'b1; arvalid[1] = 1'b1;
      serve_read(0, 8'd0);
      serve_read(1, 8'd1);
      serve_write(0, 8'd0, 0, 1'b0);

      // 5: m1 write len=3 with early wlast on beat 1; error is sticky
      len[1] = 8'd3; awvalid[1] = 1'b1;
      serve_write(1, 8'd3, 1, 1'b1);
      len[0] = 8'd0; arvalid[0] = 1'b1;
      serve_read(0, 8'd0);
      chk("err_sticky", arb_wlast_err, 1);

      // 6: reset pulsed during second read beat
      len[0] = 8'd3; arvalid[0] = 1'b1;
      tick();
      chk("t6_addr_phase", s0_if.arvalid, 1);
      s0_if.arready = 1'b1;
      tick();
      s0_if.arready = 1'b0; arvalid[0] = 1'b0;
      s0_if.rvalid = 1'b1; s0_if.rlast = 1'b0; rready[0] = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rvalid_rst", rvalid_o[0], 0);
      chk("t6_rready_rst", s0_if.rready, 0);
      chk("t6_busy_rst", arb_busy, 0);
      chk("t6_gnt_rst", arb_gnt, 0);
      chk("t6_err_rst", arb_wlast_err, 0);
      s0_if.rvalid = 1'b0; rready[0] = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      arvalid[0] = 1'b1;
      serve_read(0, 8'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
